// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 32;

    // addi x0,x0,0
    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    typedef struct packed {
        logic            req;
        logic [PC_W-1:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
    } imem_rsp_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc4;
    } fetch_out_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst,pc} holding buffer for a response that arrives while decode is stalled.
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_SIZE    = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] push_inst,
    input  logic [PC_SIZE-1:0]    push_pc,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] pop_inst,
    output logic [PC_SIZE-1:0]    pop_pc
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            full     <= 1'b0;
            pop_inst <= '0;
            pop_pc   <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full     <= 1'b1;
            pop_inst <= push_inst;
            pop_pc   <= push_pc;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding req/gnt+rvalid transaction, redirect kill,
// and a registered IF/ID payload that holds under stall.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned            PC_SIZE    = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [PC_SIZE-1:0]     RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]  NOP_INST   = fetch_ctrl_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [PC_SIZE-1:0]    br_target,
    output logic                  mem_req,
    output logic [PC_SIZE-1:0]    mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [PC_SIZE-1:0]    pc,
    output logic [PC_SIZE-1:0]    pc4
);

    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

    fetch_state_e          state_q, state_d;
    logic [PC_SIZE-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_SIZE-1:0]    req_addr_q, issued_pc_q, target_aligned;
    logic                  drop_q;
    logic                  out_free, rsp_live, skid_push, skid_pop, skid_full;
    logic [DATA_WIDTH-1:0] skid_inst;
    logic [PC_SIZE-1:0]    skid_pc;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_inst_q;
    logic [PC_SIZE-1:0]    out_pc_q, out_pc4_q;

    assign target_aligned = br_target & ~PC_SIZE'(3);
    assign out_free       = !out_valid_q || !stall;
    assign rsp_live       = (state_q == WAIT) && mem_rvalid && !drop_q && !br_taken;
    assign skid_push      = rsp_live && !out_free;
    assign skid_pop       = (state_q == HOLD) && skid_full && !stall && !br_taken;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (mem_gnt) state_d = WAIT;
            WAIT:    if (mem_rvalid) state_d = skid_push ? HOLD : REQ;
            HOLD:    if (br_taken || !stall) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == REQ);
        mem_addr = req_addr_q;
        if_valid = out_valid_q;
        inst     = out_inst_q;
        pc       = out_pc_q;
        pc4      = out_pc4_q;
    end

    // A redirect that lands while a request is already presented leaves drop_q set, so the
    // eventual grant must not advance fetch_pc past the redirected target.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (br_taken)
            fetch_pc_d = target_aligned;
        else if (state_q == REQ && mem_gnt && !drop_q)
            fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    // req_addr_q is captured only when entering REQ, which keeps mem_addr stable until gnt.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            drop_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (state_q != REQ && state_d == REQ)
                req_addr_q <= fetch_pc_d;
            if (state_q == REQ && mem_gnt)
                issued_pc_q <= req_addr_q;
            if (state_q == WAIT && mem_rvalid)
                drop_q <= 1'b0;
            else if (br_taken && (state_q == REQ || state_q == WAIT))
                drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
            out_pc_q    <= RESET_PC;
            out_pc4_q   <= RESET_PC + PC_STEP;
        end else if (br_taken) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
        end else if (rsp_live && out_free) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= mem_rdata;
            out_pc_q    <= issued_pc_q;
            out_pc4_q   <= issued_pc_q + PC_STEP;
        end else if (skid_pop) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= skid_inst;
            out_pc_q    <= skid_pc;
            out_pc4_q   <= skid_pc + PC_STEP;
        end else if (!stall) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
        end
    end

    fetch_skid_buf #(
        .PC_SIZE    (PC_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .arst      (arst),
        .push      (skid_push),
        .pop       (skid_pop),
        .flush     (br_taken),
        .push_inst (mem_rdata),
        .push_pc   (issued_pc_q),
        .full      (skid_full),
        .pop_inst  (skid_inst),
        .pop_pc    (skid_pc)
    );

    a_addr_stable: assert property (@(posedge clk) disable iff (arst)
        (mem_req && !mem_gnt) |=> $stable(mem_addr));
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (arst)
        mem_rvalid |-> (state_q == WAIT));
    a_addr_aligned: assert property (@(posedge clk) disable iff (arst)
        mem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: imem responder pushes expected {pc,inst}, consumer pops.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        if_valid;
    logic [31:0] inst, pc, pc4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    bit          gnt_allow = 1'b1;
    int unsigned rsp_delay = 1;
    bit          pend = 1'b0, pend_stale = 1'b0, req_stale = 1'b0;
    logic [31:0] pend_addr = '0;
    int unsigned cnt = 0;

    fetch_ctrl #(
        .PC_SIZE    (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .if_valid   (if_valid),
        .inst       (inst),
        .pc         (pc),
        .pc4        (pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // imem responder: decides gnt/rvalid for the coming rising edge; a response is stale if
    // any redirect was driven between its request being presented and its rvalid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (arst) begin
                pend = 0; pend_stale = 0; req_stale = 0;
                mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
            end else begin
                mem_rvalid = 0;
                mem_gnt = 0;
                if (pend) begin
                    if (br_taken) pend_stale = 1;
                    cnt--;
                    if (cnt == 0) begin
                        mem_rvalid = 1;
                        mem_rdata = word_at(pend_addr);
                        pend = 0;
                        if (!pend_stale) begin
                            e.pc = pend_addr;
                            e.inst = word_at(pend_addr);
                            exp_q.push_back(e);
                        end
                    end
                end
                if (mem_req) begin
                    if (gnt_allow && !pend) begin
                        mem_gnt = 1; pend = 1; pend_addr = mem_addr; cnt = rsp_delay;
                        pend_stale = req_stale || br_taken;
                        req_stale = 0;
                    end else if (br_taken) begin
                        req_stale = 1;
                    end
                end
            end
        end
    end

    // Decode side: an instruction is consumed when valid, not stalled and not redirected.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (arst || br_taken) begin
                exp_q.delete();
            end else if (if_valid && !stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: pc=%h inst=%h, required no instruction", pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    if (inst !== e.inst || pc !== e.pc || pc4 !== e.pc + 32'd4) begin
                        failures++;
                        $display("FAIL sb_inst: pc=%h inst=%h pc4=%h, required pc=%h inst=%h pc4=%h",
                                 pc, inst, pc4, e.pc, e.inst, e.pc + 32'd4);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req: %b required 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: %h required 0", mem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: %b required 0", if_valid); end
        checks++; if (inst !== NOP) begin failures++; $display("FAIL rst_inst: %h required %h", inst, NOP); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc: %h required 0", pc); end
        checks++; if (pc4 !== 32'h4) begin failures++; $display("FAIL rst_pc4: %h required 4", pc4); end
        arst = 1'b0;
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL t1_req0: req=%b addr=%h required 1/0", mem_req, mem_addr); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL t1_wait: req=%b valid=%b required 0/0", mem_req, if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || inst !== word_at(32'h0) || pc !== 32'h0 || pc4 !== 32'h4) begin
            failures++; $display("FAIL t1_out0: valid=%b inst=%h pc=%h pc4=%h required 1/%h/0/4", if_valid, inst, pc, pc4, word_at(32'h0)); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin failures++; $display("FAIL t1_req4: req=%b addr=%h required 1/4", mem_req, mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (if_valid !== 1'b1 || pc !== 32'h4) begin failures++; $display("FAIL t1_rate: valid=%b pc=%h required 1/4", if_valid, pc); end
    endtask

    task automatic test_stall();
        int n = 0;
        while (!(if_valid && pc == 32'h8) && n < 20) begin @(negedge clk); n++; end
        checks++; if (!(if_valid && pc == 32'h8)) begin failures++; $display("FAIL t2_timeout: pc=%h required 8", pc); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || pc !== 32'h8) begin failures++; $display("FAIL t2_hold: valid=%b pc=%h required 1/8", if_valid, pc); end
        end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL t2_noreq: req=%b required 0", mem_req); end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || pc !== 32'hC || inst !== word_at(32'hC)) begin
            failures++; $display("FAIL t2_skid: valid=%b pc=%h inst=%h required 1/c/%h", if_valid, pc, inst, word_at(32'hC)); end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        rsp_delay = 3;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin failures++; $display("FAIL t3_req10: req=%b addr=%h required 1/10", mem_req, mem_addr); end
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h103;
        @(negedge clk);
        br_taken = 1'b0;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL t3_kill: valid=%b required 0", if_valid); end
        while (!mem_req && n < 10) begin
            @(negedge clk); n++;
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL t3_stale: valid=%b pc=%h required 0", if_valid, pc); end
        end
        rsp_delay = 1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL t3_addr: req=%b addr=%h required 1/100", mem_req, mem_addr); end
        n = 0;
        while (!if_valid && n < 10) begin @(negedge clk); n++; end
        checks++; if (if_valid !== 1'b1 || pc !== 32'h100) begin failures++; $display("FAIL t3_out: valid=%b pc=%h required 1/100", if_valid, pc); end
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        while (!mem_req && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h200;
        @(negedge clk);
        br_taken = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || if_valid !== 1'b0) begin
            failures++; $display("FAIL t4a_redir: req=%b addr=%h valid=%b required 1/200/0", mem_req, mem_addr, if_valid); end
        n = 0;
        while (!if_valid && n < 10) begin @(negedge clk); n++; end
        checks++; if (if_valid !== 1'b1 || pc !== 32'h200) begin failures++; $display("FAIL t4a_out: valid=%b pc=%h required 1/200", if_valid, pc); end
    endtask

    task automatic test_redirect_req();
        int n = 0;
        logic [31:0] old_addr;
        gnt_allow = 1'b0;
        old_addr = mem_addr;
        checks++; if (mem_req !== 1'b1 || old_addr !== 32'h204) begin failures++; $display("FAIL t4b_req: req=%b addr=%h required 1/204", mem_req, old_addr); end
        br_taken = 1'b1; br_target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            br_taken = 1'b0;
            checks++; if (mem_req !== 1'b1 || mem_addr !== old_addr) begin failures++; $display("FAIL t4b_hold: req=%b addr=%h required 1/%h", mem_req, mem_addr, old_addr); end
        end
        gnt_allow = 1'b1;
        @(negedge clk);
        while (!mem_req && n < 10) begin @(negedge clk); n++; end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || if_valid !== 1'b0) begin
            failures++; $display("FAIL t4b_addr: req=%b addr=%h valid=%b required 1/300/0", mem_req, mem_addr, if_valid); end
        n = 0;
        while (!if_valid && n < 10) begin @(negedge clk); n++; end
        checks++; if (if_valid !== 1'b1 || pc !== 32'h300) begin failures++; $display("FAIL t4b_out: valid=%b pc=%h required 1/300", if_valid, pc); end
    endtask

    task automatic test_wrap_and_async_reset();
        int n = 0;
        br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
        @(negedge clk);
        br_taken = 1'b0;
        while (!(if_valid && pc == 32'hFFFF_FFFC) && n < 30) begin @(negedge clk); n++; end
        checks++; if (!(if_valid && pc == 32'hFFFF_FFFC)) begin failures++; $display("FAIL t5_timeout: pc=%h required fffffffc", pc); end
        checks++; if (pc4 !== 32'h0) begin failures++; $display("FAIL t5_pc4: %h required 0", pc4); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL t5_wrap: req=%b addr=%h required 1/0", mem_req, mem_addr); end
        rsp_delay = 3;
        @(negedge clk);
        arst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL t5_rst_mem: req=%b addr=%h required 0/0", mem_req, mem_addr); end
        checks++; if (if_valid !== 1'b0 || inst !== NOP || pc !== 32'h0 || pc4 !== 32'h4) begin
            failures++; $display("FAIL t5_rst_out: valid=%b inst=%h pc=%h pc4=%h required 0/%h/0/4", if_valid, inst, pc, pc4, NOP); end
        repeat (2) @(negedge clk);
        rsp_delay = 1;
        arst = 1'b0;
        n = 0;
        while (!if_valid && n < 10) begin @(negedge clk); n++; end
        checks++; if (if_valid !== 1'b1 || pc !== 32'h0 || inst !== word_at(32'h0)) begin
            failures++; $display("FAIL t5_restart: valid=%b pc=%h inst=%h required 1/0/%h", if_valid, pc, inst, word_at(32'h0)); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_req();
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
